// File: rtl/scan_sequencer_nd_pkg.sv
// Shared types and helpers for the N-channel scan sequencer.
// Covers the FSM state encoding, the DAC park code and the lane offsets into packed per-channel cfg vectors.
package scan_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        LEAD,
        RUN,
        DONE
    } seq_state_t;

    // Mid-scale DAC code the galvos rest at while not scanning.
    function automatic int unsigned park_code(input int unsigned dac_w);
        return 32'd1 << (dac_w - 1);
    endfunction

    // LSB of channel idx inside a packed vector of field_w-wide lanes.
    function automatic int unsigned field_lsb(input int unsigned idx, input int unsigned field_w);
        return idx * field_w;
    endfunction

endpackage

// File: rtl/scan_sequencer_nd_trig.sv
// One trigger channel: high while pc lies in [delay, delay+width-1] of a point.
// The compare uses the upcoming pc, so the registered output lines up with pc itself.
module trig_window #(
    parameter int unsigned CFG_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CFG_W-1:0] pc,
    input  logic [CFG_W-1:0] cpp,
    input  logic [CFG_W-1:0] delay,
    input  logic [CFG_W-1:0] width,
    output logic             q
);

    logic hit;

    // pc never reaches cpp, so the window end is clipped at cpp-1 implicitly.
    // Comparing pc-delay against width avoids overflow of delay+width.
    always_comb begin
        hit = en && (width != '0) && (delay < cpp) && (pc >= delay) && ((pc - delay) < width);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= hit;
        end
    end

endmodule

// File: rtl/scan_sequencer_nd.sv
// 2D/3D galvo scan sequencer: walks the X/Y waveform tables through point, line-repeat and frame loops.
// It drives the DAC pair and N_TRIG per-point trigger windows.
module scan_sequencer_nd
    import scan_seq_pkg::*;
#(
    parameter int unsigned CFG_W    = 16,
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned DAC_W    = 14,
    parameter int unsigned N_TRIG   = 2,
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned STATE_2D = 2,
    parameter int unsigned STATE_3D = 3
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic                    frame_rdy,
    input  logic                    kill_process,
    input  logic [CFG_W-1:0]        system_state,
    input  logic [CFG_W-1:0]        cfg_x_points,
    input  logic [CFG_W-1:0]        cfg_x_blocks,
    input  logic [CFG_W-1:0]        cfg_y_points,
    input  logic [CFG_W-1:0]        cfg_cycles_per_point,
    input  logic [CFG_W-1:0]        cfg_da_delay,
    input  logic                    cfg_serpentine,
    input  logic [N_TRIG*CFG_W-1:0] cfg_trig_delay,
    input  logic [N_TRIG*CFG_W-1:0] cfg_trig_width,
    output logic [ADDR_W-1:0]       tbl_x_addr,
    input  logic [CFG_W-1:0]        tbl_x_data,
    output logic [ADDR_W-1:0]       tbl_y_addr,
    input  logic [CFG_W-1:0]        tbl_y_data,
    output logic [DAC_W-1:0]        dac_x,
    output logic [DAC_W-1:0]        dac_y,
    output logic                    da_generating,
    output logic [N_TRIG-1:0]       trig,
    output logic                    busy,
    output logic                    proc_finished,
    output logic                    cfg_err
);

    localparam logic [DAC_W-1:0] PARK      = DAC_W'(park_code(DAC_W));
    localparam int unsigned      TW        = N_TRIG * CFG_W;
    localparam logic [31:0]      TBL_DEPTH = 32'd1 << ADDR_W;
    localparam logic [CFG_W-1:0] ONE       = CFG_W'(1);

    seq_state_t state, state_nxt;

    logic [CFG_W-1:0] x_q, b_q, y_q, cpp_q, da_q;
    logic             serp_q, mode_3d_q;
    logic [TW-1:0]    td_q, tw_q;

    logic [CFG_W-1:0] lead_cnt, pc, xi, bi, yi;
    logic [CFG_W-1:0] lead_n, pc_n, xi_n, bi_n, yi_n;
    logic             start, cfg_ok, last_cycle, run_nxt, odd_line;
    logic [ADDR_W-1:0] x_addr_nxt;

    always_comb begin
        start = frame_rdy && !kill_process &&
                ((system_state == CFG_W'(STATE_2D)) || (system_state == CFG_W'(STATE_3D)));
        cfg_ok = (x_q != '0) && (b_q != '0) && (y_q != '0) &&
                 (32'(cpp_q) > READ_LAT) && (32'(x_q) <= TBL_DEPTH) &&
                 !(mode_3d_q && (32'(y_q) > TBL_DEPTH));
        last_cycle = (pc == cpp_q - ONE) && (xi == x_q - ONE) &&
                     (bi == b_q - ONE) && (yi == y_q - ONE);
    end

    always_comb begin
        state_nxt = state;
        lead_n    = '0;
        pc_n      = pc;
        xi_n      = xi;
        bi_n      = bi;
        yi_n      = yi;
        case (state)
            IDLE: if (start) state_nxt = ARM;
            ARM:  state_nxt = cfg_ok ? LEAD : IDLE;
            LEAD: begin
                if ((da_q == '0) || (lead_cnt == da_q - ONE)) state_nxt = RUN;
                else lead_n = lead_cnt + ONE;
            end
            RUN: begin
                if (last_cycle) begin
                    state_nxt = DONE;
                end else if (pc == cpp_q - ONE) begin
                    pc_n = '0;
                    if (xi == x_q - ONE) begin
                        xi_n = '0;
                        if (bi == b_q - ONE) begin
                            bi_n = '0;
                            yi_n = yi + ONE;
                        end else begin
                            bi_n = bi + ONE;
                        end
                    end else begin
                        xi_n = xi + ONE;
                    end
                end else begin
                    pc_n = pc + ONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (kill_process && (state != IDLE)) state_nxt = IDLE;
        if (state_nxt != LEAD) lead_n = '0;
        if (state_nxt != RUN) begin
            pc_n = '0;
            xi_n = '0;
            bi_n = '0;
            yi_n = '0;
        end
    end

    // Line parity of yi*B+bi without a multiplier.
    always_comb begin
        run_nxt    = (state_nxt == RUN);
        odd_line   = (yi_n[0] & b_q[0]) ^ bi_n[0];
        x_addr_nxt = (serp_q && odd_line) ? ADDR_W'(x_q - ONE - xi_n) : ADDR_W'(xi_n);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= IDLE;
            lead_cnt      <= '0;
            pc            <= '0;
            xi            <= '0;
            bi            <= '0;
            yi            <= '0;
            x_q           <= '0;
            b_q           <= '0;
            y_q           <= '0;
            cpp_q         <= '0;
            da_q          <= '0;
            serp_q        <= 1'b0;
            mode_3d_q     <= 1'b0;
            td_q          <= '0;
            tw_q          <= '0;
            tbl_x_addr    <= '0;
            tbl_y_addr    <= '0;
            dac_x         <= PARK;
            dac_y         <= PARK;
            cfg_err       <= 1'b0;
            proc_finished <= 1'b0;
        end else begin
            state    <= state_nxt;
            lead_cnt <= lead_n;
            pc       <= pc_n;
            xi       <= xi_n;
            bi       <= bi_n;
            yi       <= yi_n;
            if ((state == IDLE) && start) begin
                x_q       <= cfg_x_points;
                b_q       <= cfg_x_blocks;
                y_q       <= cfg_y_points;
                cpp_q     <= cfg_cycles_per_point;
                da_q      <= cfg_da_delay;
                serp_q    <= cfg_serpentine;
                td_q      <= cfg_trig_delay;
                tw_q      <= cfg_trig_width;
                mode_3d_q <= (system_state == CFG_W'(STATE_3D));
            end
            tbl_x_addr <= run_nxt ? x_addr_nxt : '0;
            tbl_y_addr <= (run_nxt && mode_3d_q) ? ADDR_W'(yi_n) : '0;
            if (!run_nxt) begin
                dac_x <= PARK;
                dac_y <= PARK;
            end else if ((state == RUN) && (pc == CFG_W'(READ_LAT))) begin
                dac_x <= tbl_x_data[DAC_W-1:0];
                dac_y <= tbl_y_data[DAC_W-1:0];
            end
            cfg_err       <= (state == ARM) && !cfg_ok && !kill_process;
            proc_finished <= (state == RUN) && last_cycle && !kill_process;
        end
    end

    always_comb begin
        busy          = (state != IDLE);
        da_generating = (state == RUN);
    end

    for (genvar k = 0; k < N_TRIG; k++) begin : g_trig
        trig_window #(.CFG_W(CFG_W)) u_trig (
            .clk   (sys_clk),
            .rst_n (sys_rst_n),
            .en    (run_nxt),
            .pc    (pc_n),
            .cpp   (cpp_q),
            .delay (td_q[field_lsb(k, CFG_W) +: CFG_W]),
            .width (tw_q[field_lsb(k, CFG_W) +: CFG_W]),
            .q     (trig[k])
        );
    end

endmodule

// File: tb/tb_scan_sequencer_nd.sv
// Directed bench for scan_sequencer_nd with a 1-cycle-latency table model.
// Each scenario task drives its stimulus and compares outputs against hand-derived values.
module tb_scan_sequencer_nd;

    localparam int unsigned CFG_W  = 16;
    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DAC_W  = 14;
    localparam int unsigned N_TRIG = 2;

    logic                    sys_clk;
    logic                    sys_rst_n;
    logic                    frame_rdy;
    logic                    kill_process;
    logic [CFG_W-1:0]        system_state;
    logic [CFG_W-1:0]        cfg_x_points, cfg_x_blocks, cfg_y_points;
    logic [CFG_W-1:0]        cfg_cycles_per_point, cfg_da_delay;
    logic                    cfg_serpentine;
    logic [N_TRIG*CFG_W-1:0] cfg_trig_delay, cfg_trig_width;
    logic [ADDR_W-1:0]       tbl_x_addr, tbl_y_addr;
    logic [CFG_W-1:0]        tbl_x_data, tbl_y_data;
    logic [DAC_W-1:0]        dac_x, dac_y;
    logic                    da_generating, busy, proc_finished, cfg_err;
    logic [N_TRIG-1:0]       trig;
    logic                    tbl_override;

    int vectors;
    int miscompares;

    scan_sequencer_nd #(
        .CFG_W(CFG_W), .ADDR_W(ADDR_W), .DAC_W(DAC_W), .N_TRIG(N_TRIG),
        .READ_LAT(1), .STATE_2D(2), .STATE_3D(3)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .frame_rdy(frame_rdy),
        .kill_process(kill_process), .system_state(system_state),
        .cfg_x_points(cfg_x_points), .cfg_x_blocks(cfg_x_blocks),
        .cfg_y_points(cfg_y_points), .cfg_cycles_per_point(cfg_cycles_per_point),
        .cfg_da_delay(cfg_da_delay), .cfg_serpentine(cfg_serpentine),
        .cfg_trig_delay(cfg_trig_delay), .cfg_trig_width(cfg_trig_width),
        .tbl_x_addr(tbl_x_addr), .tbl_x_data(tbl_x_data),
        .tbl_y_addr(tbl_y_addr), .tbl_y_data(tbl_y_data),
        .dac_x(dac_x), .dac_y(dac_y), .da_generating(da_generating),
        .trig(trig), .busy(busy), .proc_finished(proc_finished), .cfg_err(cfg_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Synchronous table: data for an address appears one cycle later.
    always @(posedge sys_clk) begin
        tbl_x_data <= tbl_override ? 16'hFFFF : (16'h0100 + {2'b00, tbl_x_addr});
        tbl_y_data <= tbl_override ? 16'h1234 : (16'h0200 + {2'b00, tbl_y_addr});
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_cfg(input int x, input int b, input int y, input int cpp, input int da,
                           input logic serp, input int d0, input int w0, input int d1, input int w1);
        cfg_x_points         = 16'(x);
        cfg_x_blocks         = 16'(b);
        cfg_y_points         = 16'(y);
        cfg_cycles_per_point = 16'(cpp);
        cfg_da_delay         = 16'(da);
        cfg_serpentine       = serp;
        cfg_trig_delay       = {16'(d1), 16'(d0)};
        cfg_trig_width       = {16'(w1), 16'(w0)};
    endtask

    task automatic start_pulse(input int st);
        system_state = 16'(st);
        frame_rdy    = 1'b1;
        step();
        frame_rdy    = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if ({dac_x, dac_y} !== {14'h2000, 14'h2000}) begin
            miscompares++;
            $display("FAIL reset_dac got=%h exp=%h", {dac_x, dac_y}, {14'h2000, 14'h2000});
        end
        vectors++;
        if ({tbl_x_addr, tbl_y_addr, trig, da_generating, busy, proc_finished, cfg_err} !== 34'd0) begin
            miscompares++;
            $display("FAIL reset_flags got=%h exp=0",
                     {tbl_x_addr, tbl_y_addr, trig, da_generating, busy, proc_finished, cfg_err});
        end
    endtask

    task automatic test_basic_2d();
        int n;
        logic [32:0] obs, exp;
        set_cfg(4, 1, 1, 4, 2, 1'b0, 1, 2, 3, 5);
        start_pulse(2);
        vectors++;
        if ({busy, da_generating} !== 2'b10) begin
            miscompares++;
            $display("FAIL basic_arm got=%b exp=10", {busy, da_generating});
        end
        n = 0;
        while (da_generating !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        vectors++;
        if (n != 3) begin
            miscompares++;
            $display("FAIL basic_lead got=%0d exp=3", n);
        end
        for (int cyc = 0; cyc < 16; cyc++) begin
            int pc, p;
            pc  = cyc % 4;
            p   = cyc / 4;
            obs = {tbl_x_addr, tbl_y_addr, trig, da_generating, proc_finished, busy};
            exp = {14'(p), 14'd0, (pc == 3), (pc == 1 || pc == 2), 1'b1, 1'b0, 1'b1};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL basic_run cyc=%0d got=%h exp=%h", cyc, obs, exp);
            end
            if (pc >= 2) begin
                vectors++;
                if ({dac_x, dac_y} !== {14'h0100 + 14'(p), 14'h0200}) begin
                    miscompares++;
                    $display("FAIL basic_dac cyc=%0d got=%h exp=%h", cyc, {dac_x, dac_y},
                             {14'h0100 + 14'(p), 14'h0200});
                end
            end
            step();
        end
        vectors++;
        if ({proc_finished, busy, da_generating, trig, dac_x, dac_y} !== {5'b11000, 14'h2000, 14'h2000}) begin
            miscompares++;
            $display("FAIL basic_done got=%h exp=%h", {proc_finished, busy, da_generating, trig, dac_x, dac_y},
                     {5'b11000, 14'h2000, 14'h2000});
        end
        step();
        vectors++;
        if ({proc_finished, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL basic_idle got=%b exp=00", {proc_finished, busy});
        end
    endtask

    task automatic test_serpentine_3d();
        int n;
        int exp_x [12] = '{0, 1, 2, 2, 1, 0, 0, 1, 2, 2, 1, 0};
        logic [30:0] obs, exp;
        set_cfg(3, 2, 2, 2, 0, 1'b1, 0, 0, 5, 3);
        start_pulse(3);
        n = 0;
        while (da_generating !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        vectors++;
        if (n != 2) begin
            miscompares++;
            $display("FAIL serp_lead got=%0d exp=2", n);
        end
        for (int cyc = 0; cyc < 24; cyc++) begin
            int p;
            p   = cyc / 2;
            obs = {tbl_x_addr, tbl_y_addr, trig, da_generating};
            exp = {14'(exp_x[p]), 14'(p / 6), 2'b00, 1'b1};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL serp_run cyc=%0d got=%h exp=%h", cyc, obs, exp);
            end
            step();
        end
        vectors++;
        if (proc_finished !== 1'b1) begin
            miscompares++;
            $display("FAIL serp_done got=%b exp=1", proc_finished);
        end
        step();
    endtask

    task automatic test_mode_2d();
        int run_cnt, pf_cnt, ynz, busy_cnt;
        run_cnt = 0; pf_cnt = 0; ynz = 0; busy_cnt = 0;
        set_cfg(2, 1, 3, 2, 0, 1'b0, 0, 1, 1, 1);
        start_pulse(2);
        for (int i = 0; i < 30; i++) begin
            step();
            if (da_generating === 1'b1) run_cnt++;
            if (proc_finished === 1'b1) pf_cnt++;
            if (tbl_y_addr !== 14'd0) ynz++;
        end
        vectors++;
        if ({run_cnt, pf_cnt, ynz} !== {32'd12, 32'd1, 32'd0}) begin
            miscompares++;
            $display("FAIL mode2d_counts got=%0d/%0d/%0d exp=12/1/0", run_cnt, pf_cnt, ynz);
        end
        system_state = 16'd5;
        frame_rdy    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (busy !== 1'b0) busy_cnt++;
        end
        frame_rdy = 1'b0;
        vectors++;
        if (busy_cnt != 0) begin
            miscompares++;
            $display("FAIL bad_state_busy got=%0d exp=0", busy_cnt);
        end
    endtask

    task automatic test_kill();
        int n, pf_cnt, busy_cnt;
        pf_cnt = 0; busy_cnt = 0;
        set_cfg(4, 1, 1, 4, 0, 1'b0, 0, 4, 2, 1);
        start_pulse(2);
        n = 0;
        while (da_generating !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        for (int i = 0; i < 9; i++) step();
        vectors++;
        if ({tbl_x_addr, trig} !== {14'd2, 2'b01}) begin
            miscompares++;
            $display("FAIL kill_pre got=%h exp=%h", {tbl_x_addr, trig}, {14'd2, 2'b01});
        end
        kill_process = 1'b1;
        step();
        kill_process = 1'b0;
        vectors++;
        if ({busy, da_generating, proc_finished, trig, dac_x, dac_y} !== {5'b00000, 14'h2000, 14'h2000}) begin
            miscompares++;
            $display("FAIL kill_post got=%h exp=%h", {busy, da_generating, proc_finished, trig, dac_x, dac_y},
                     {5'b00000, 14'h2000, 14'h2000});
        end
        for (int i = 0; i < 5; i++) begin
            step();
            if (proc_finished === 1'b1) pf_cnt++;
            if (busy !== 1'b0) busy_cnt++;
        end
        vectors++;
        if (pf_cnt + busy_cnt != 0) begin
            miscompares++;
            $display("FAIL kill_quiet got=%0d/%0d exp=0/0", pf_cnt, busy_cnt);
        end
        start_pulse(2);
        n = 0;
        while (da_generating !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        vectors++;
        if ({da_generating, tbl_x_addr, trig} !== {1'b1, 14'd0, 2'b01}) begin
            miscompares++;
            $display("FAIL kill_restart got=%h exp=%h", {da_generating, tbl_x_addr, trig}, {1'b1, 14'd0, 2'b01});
        end
        n = 0;
        while (busy !== 1'b0 && n < 40) begin
            step();
            n++;
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL kill_drain got=%b exp=0", busy);
        end
    endtask

    task automatic test_reject();
        int err_cnt, run_cnt, busy_cnt;
        for (int t = 0; t < 2; t++) begin
            err_cnt = 0; run_cnt = 0;
            if (t == 0) set_cfg(4, 1, 1, 1, 0, 1'b0, 0, 1, 0, 1);
            else        set_cfg(0, 1, 1, 4, 0, 1'b0, 0, 1, 0, 1);
            start_pulse(2);
            for (int i = 0; i < 6; i++) begin
                step();
                if (cfg_err === 1'b1) err_cnt++;
                if (da_generating === 1'b1) run_cnt++;
            end
            vectors++;
            if ({err_cnt, run_cnt} !== {32'd1, 32'd0}) begin
                miscompares++;
                $display("FAIL reject%0d got=%0d/%0d exp=1/0", t, err_cnt, run_cnt);
            end
        end
        busy_cnt = 0;
        set_cfg(4, 1, 1, 4, 0, 1'b0, 0, 1, 0, 1);
        kill_process = 1'b1;
        start_pulse(2);
        kill_process = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (busy !== 1'b0) busy_cnt++;
            step();
        end
        vectors++;
        if (busy_cnt != 0) begin
            miscompares++;
            $display("FAIL kill_idle_start got=%0d exp=0", busy_cnt);
        end
    endtask

    task automatic test_dac_trunc_and_reset();
        int n;
        tbl_override = 1'b1;
        set_cfg(2, 1, 1, 4, 0, 1'b0, 0, 1, 0, 1);
        start_pulse(3);
        n = 0;
        while (da_generating !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({dac_x, dac_y} !== {14'h3FFF, 14'h1234}) begin
                miscompares++;
                $display("FAIL dac_trunc pc=%0d got=%h exp=%h", i + 2, {dac_x, dac_y}, {14'h3FFF, 14'h1234});
            end
            step();
        end
        #2 sys_rst_n = 1'b0;
        #1;
        vectors++;
        if ({dac_x, dac_y, tbl_x_addr, tbl_y_addr, trig, da_generating, busy, proc_finished, cfg_err} !==
            {14'h2000, 14'h2000, 34'd0}) begin
            miscompares++;
            $display("FAIL async_reset got=%h exp=%h",
                     {dac_x, dac_y, tbl_x_addr, tbl_y_addr, trig, da_generating, busy, proc_finished, cfg_err},
                     {14'h2000, 14'h2000, 34'd0});
        end
        #1 sys_rst_n = 1'b1;
        tbl_override = 1'b0;
        step();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_busy got=%b exp=0", busy);
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        sys_rst_n    = 1'b0;
        frame_rdy    = 1'b0;
        kill_process = 1'b0;
        system_state = '0;
        tbl_override = 1'b0;
        tbl_x_data   = '0;
        tbl_y_data   = '0;
        set_cfg(0, 0, 0, 0, 0, 1'b0, 0, 0, 0, 0);
        #12 sys_rst_n = 1'b1;
        test_reset();
        test_basic_2d();
        test_serpentine_3d();
        test_mode_2d();
        test_kill();
        test_reject();
        test_dac_trunc_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
